// File: rtl/game_pkg.sv
// Shared definitions for the game status path: status codes, FSM states, player id.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package game_pkg;

    localparam logic [7:0] ST_PLAYING     = 8'h00;
    localparam logic [7:0] ST_ERR_INVALID = 8'h01;
    localparam logic [7:0] ST_WIN_P1      = 8'h02;
    localparam logic [7:0] ST_WIN_P2      = 8'h03;
    localparam logic [7:0] ST_DRAW        = 8'h04;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        ERROR = 2'd2,
        OVER  = 2'd3
    } state_t;

    // 0 = player 1, 1 = player 2
    typedef logic player_t;

    // WIN code credited to the given player
    function automatic logic [7:0] win_code(input player_t p);
        return p ? ST_WIN_P2 : ST_WIN_P1;
    endfunction

endpackage

// File: rtl/game_turn_timer.sv
// Saturating per-turn cycle counter with clear, enable and an expiry flag.
// Latency: count updates one cycle after en/clr; expired decodes the current count.
// Backpressure: none; clear has priority over enable, count holds at all-ones.
module game_turn_timer #(
    parameter int unsigned LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count,
    output logic        expired
);

    // Count enabled cycles, restarting on clear and never wrapping
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

    assign expired = (count == (LIMIT - 32'd1));

endmodule

// File: rtl/game_status_ctrl.sv
// Sequences the game status register (turns, errors, win/draw/timeout); sole writer. Timer: GAME_TURN_TIMER_EN.
// Latency: event sampled at edge N gives status_we/status_data in the cycle after N; all outputs registered.
// Backpressure: none; CHECK waits indefinitely for check_valid, OVER waits for restart.
module game_status_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 500_000_000,
    parameter int unsigned ERR_CYCLES  = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        move_done,
    input  logic        move_invalid,
    input  logic        check_valid,
    input  logic        win_detected,
    input  logic        board_full,
    output logic        status_we,
    output logic [7:0]  status_data,
    output player_t     cur_player,
    output logic [31:0] turn_time,
    output logic        game_over
);

    state_t      state;
    logic [31:0] err_cnt;
    logic        turn_change;
    logic        timeout;

    // Checker cleared the move with no win and no draw: hand the turn over
    assign turn_change = (state == CHECK) && check_valid && !win_detected && !board_full;

`ifdef GAME_TURN_TIMER_EN
    logic timer_clr;
    logic timer_en;
    logic timer_exp;

    // Time runs only while the current player is deciding; a new turn or game clears it
    assign timer_clr = restart || turn_change;
    assign timer_en  = (state == PLAY);

    game_turn_timer #(
        .LIMIT(TURN_CYCLES)
    ) u_turn_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .count   (turn_time),
        .expired (timer_exp)
    );

    assign timeout = timer_exp;
`else
    // No turn timer in this build: TURN_CYCLES is unused and a turn never times out
    assign turn_time = '0;
    assign timeout   = 1'b0;
`endif

    // Game FSM; every status write is a one-cycle strobe issued only when the code changes
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PLAY;
            err_cnt     <= '0;
            status_we   <= 1'b0;
            status_data <= ST_PLAYING;
            cur_player  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            status_we <= 1'b0;
            if (restart) begin
                // Unconditional write so a restart is always visible to the register
                state       <= PLAY;
                err_cnt     <= '0;
                cur_player  <= 1'b0;
                game_over   <= 1'b0;
                status_data <= ST_PLAYING;
                status_we   <= 1'b1;
            end else begin
                case (state)
                    PLAY: begin
                        if (move_done) begin
                            state <= CHECK;
                        end else if (move_invalid) begin
                            state       <= ERROR;
                            err_cnt     <= '0;
                            status_data <= ST_ERR_INVALID;
                            status_we   <= (status_data != ST_ERR_INVALID);
                        end else if (timeout) begin
                            state       <= OVER;
                            game_over   <= 1'b1;
                            status_data <= win_code(~cur_player);
                            status_we   <= (status_data != win_code(~cur_player));
                        end
                    end
                    CHECK: begin
                        if (check_valid) begin
                            if (win_detected) begin
                                state       <= OVER;
                                game_over   <= 1'b1;
                                status_data <= win_code(cur_player);
                                status_we   <= (status_data != win_code(cur_player));
                            end else if (board_full) begin
                                state       <= OVER;
                                game_over   <= 1'b1;
                                status_data <= ST_DRAW;
                                status_we   <= (status_data != ST_DRAW);
                            end else begin
                                state      <= PLAY;
                                cur_player <= ~cur_player;
                            end
                        end
                    end
                    ERROR: begin
                        if (err_cnt == (ERR_CYCLES - 32'd1)) begin
                            state       <= PLAY;
                            status_data <= ST_PLAYING;
                            status_we   <= (status_data != ST_PLAYING);
                        end else begin
                            err_cnt <= err_cnt + 32'd1;
                        end
                    end
                    OVER: begin
                        // Only restart leaves OVER
                    end
                    default: begin
                        state <= PLAY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed table-driven bench for game_status_ctrl with TURN_CYCLES=8, ERR_CYCLES=4.
// Latency: inputs driven at negedge, outputs sampled 1 time unit after the posedge.
// Backpressure: n/a.
module tb_game_status_ctrl;

`ifdef GAME_TURN_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        move_done = 1'b0;
    logic        move_invalid = 1'b0;
    logic        check_valid = 1'b0;
    logic        win_detected = 1'b0;
    logic        board_full = 1'b0;
    logic        status_we;
    logic [7:0]  status_data;
    logic        cur_player;
    logic [31:0] turn_time;
    logic        game_over;

    int n_vec = 0;
    int n_bad = 0;

    game_status_ctrl #(
        .TURN_CYCLES(8),
        .ERR_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .restart      (restart),
        .move_done    (move_done),
        .move_invalid (move_invalid),
        .check_valid  (check_valid),
        .win_detected (win_detected),
        .board_full   (board_full),
        .status_we    (status_we),
        .status_data  (status_data),
        .cur_player   (cur_player),
        .turn_time    (turn_time),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         rs, md, mi, cv, wd, bf;
        bit         e_we;
        logic [7:0] e_data;
        bit         e_pl;
        bit         e_ov;
        int         e_tt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input bit rs, md, mi, cv, wd, bf,
                                input bit we, input logic [7:0] d, input bit pl,
                                input bit ov, input int tt);
        vec_t v;
        v.name = n; v.rs = rs; v.md = md; v.mi = mi; v.cv = cv; v.wd = wd; v.bf = bf;
        v.e_we = we; v.e_data = d; v.e_pl = pl; v.e_ov = ov; v.e_tt = tt;
        return v;
    endfunction

    // Compare every output; turn_time is expected to read 0 when the timer is compiled out
    task automatic check(input string n, input bit we, input logic [7:0] d, input bit pl,
                         input bit ov, input int tt);
        logic [31:0] ett;
        ett = TIMER_EN ? tt : 0;
        n_vec++;
        if (status_we !== we) begin
            n_bad++;
            $display("FAIL %s status_we got %0b want %0b", n, status_we, we);
        end
        if (status_data !== d) begin
            n_bad++;
            $display("FAIL %s status_data got %02h want %02h", n, status_data, d);
        end
        if (cur_player !== pl) begin
            n_bad++;
            $display("FAIL %s cur_player got %0b want %0b", n, cur_player, pl);
        end
        if (game_over !== ov) begin
            n_bad++;
            $display("FAIL %s game_over got %0b want %0b", n, game_over, ov);
        end
        if (turn_time !== ett) begin
            n_bad++;
            $display("FAIL %s turn_time got %0d want %0d", n, turn_time, ett);
        end
    endtask

    task automatic cyc(input bit rs, md, mi, cv, wd, bf);
        @(negedge clk);
        restart = rs; move_done = md; move_invalid = mi;
        check_valid = cv; win_detected = wd; board_full = bf;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 name           rs md mi cv wd bf  we data   pl ov tt
        vecs.push_back(mk("idle0",        0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 1));
        vecs.push_back(mk("idle1",        0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 2));
        vecs.push_back(mk("idle2",        0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 3));
        vecs.push_back(mk("p1_move",      0, 1, 0, 0, 0, 0,  0, 8'h00, 0, 0, 4));
        vecs.push_back(mk("check_wait",   0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 4));
        vecs.push_back(mk("turn_change",  0, 0, 0, 1, 0, 0,  0, 8'h00, 1, 0, 0));
        vecs.push_back(mk("p2_idle0",     0, 0, 0, 0, 0, 0,  0, 8'h00, 1, 0, 1));
        vecs.push_back(mk("p2_idle1",     0, 0, 0, 0, 0, 0,  0, 8'h00, 1, 0, 2));
        vecs.push_back(mk("invalid",      0, 0, 1, 0, 0, 0,  1, 8'h01, 1, 0, 3));
        vecs.push_back(mk("err_dwell1",   0, 0, 0, 0, 0, 0,  0, 8'h01, 1, 0, 3));
        vecs.push_back(mk("err_ign_move", 0, 1, 0, 0, 0, 0,  0, 8'h01, 1, 0, 3));
        vecs.push_back(mk("err_dwell3",   0, 0, 0, 0, 0, 0,  0, 8'h01, 1, 0, 3));
        vecs.push_back(mk("err_exit",     0, 0, 0, 0, 0, 0,  1, 8'h00, 1, 0, 3));
        vecs.push_back(mk("resume",       0, 0, 0, 0, 0, 0,  0, 8'h00, 1, 0, 4));
        vecs.push_back(mk("p2_move",      0, 1, 0, 0, 0, 0,  0, 8'h00, 1, 0, 5));
        vecs.push_back(mk("win_and_full", 0, 0, 0, 1, 1, 1,  1, 8'h03, 1, 1, 5));
        vecs.push_back(mk("over_ign_mv",  0, 1, 0, 0, 0, 0,  0, 8'h03, 1, 1, 5));
        vecs.push_back(mk("over_ign_chk", 0, 0, 0, 1, 1, 0,  0, 8'h03, 1, 1, 5));
        vecs.push_back(mk("restart_race", 1, 1, 0, 0, 0, 0,  1, 8'h00, 0, 0, 0));
        vecs.push_back(mk("post_restart", 0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 1));
        vecs.push_back(mk("restart_idem", 1, 0, 0, 0, 0, 0,  1, 8'h00, 0, 0, 0));
        vecs.push_back(mk("restart_b2b",  1, 0, 0, 0, 0, 0,  1, 8'h00, 0, 0, 0));
        vecs.push_back(mk("idle3",        0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 1));
        vecs.push_back(mk("p1_move2",     0, 1, 0, 0, 0, 0,  0, 8'h00, 0, 0, 2));
        vecs.push_back(mk("draw",         0, 0, 0, 1, 0, 1,  1, 8'h04, 0, 1, 2));
        vecs.push_back(mk("restart_draw", 1, 0, 0, 0, 0, 0,  1, 8'h00, 0, 0, 0));
        vecs.push_back(mk("done_over_inv",0, 1, 1, 0, 0, 0,  0, 8'h00, 0, 0, 1));
        vecs.push_back(mk("p1_win",       0, 0, 0, 1, 1, 0,  1, 8'h02, 0, 1, 1));
        vecs.push_back(mk("restart_win",  1, 0, 0, 0, 0, 0,  1, 8'h00, 0, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset", 0, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].rs, vecs[i].md, vecs[i].mi, vecs[i].cv, vecs[i].wd, vecs[i].bf);
            check(vecs[i].name, vecs[i].e_we, vecs[i].e_data, vecs[i].e_pl, vecs[i].e_ov, vecs[i].e_tt);
        end

`ifdef GAME_TURN_TIMER_EN
        // Player 1 idles: forfeit strobe lands 8 cycles after the turn started
        for (int k = 1; k <= 7; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            check("timeout_wait", 0, 8'h00, 0, 0, k);
        end
        cyc(0, 0, 0, 0, 0, 0);
        check("timeout", 1, 8'h03, 0, 1, 8);
        cyc(1, 0, 0, 0, 0, 0);
        check("restart_to", 1, 8'h00, 0, 0, 0);
`else
        begin
            int strobes;
            strobes = 0;
            for (int k = 0; k < 100; k++) begin
                cyc(0, 0, 0, 0, 0, 0);
                if (status_we) strobes++;
            end
            n_vec++;
            if (strobes != 0) begin
                n_bad++;
                $display("FAIL no_timeout strobes got %0d want 0", strobes);
            end
            check("no_timeout", 0, 8'h00, 0, 0, 0);
        end
`endif

        // rst together with restart in OVER: no strobe, plain reset state
        cyc(0, 1, 0, 0, 0, 0);
        check("pre_rst_move", 0, 8'h00, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 0);
        check("pre_rst_win", 1, 8'h02, 0, 1, 1);
        @(negedge clk);
        rst = 1'b1; restart = 1'b1; move_done = 1'b1;
        check_valid = 1'b0; win_detected = 1'b0;
        @(posedge clk);
        #1;
        check("rst_vs_restart", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; restart = 1'b0; move_done = 1'b0;

        // rst right after a strobe drops it and returns to the reset code
        cyc(0, 0, 1, 0, 0, 0);
        check("pre_rst_inv", 1, 8'h01, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1; move_invalid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_drop", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        check("post_rst_idle", 0, 8'h00, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
